accel_host_loader: RTL and testbench

- Host-side initiator for the matrix/vector accelerator.
- Accepts a byte-serial command stream from the host over a valid/ready input.
- Uses that stream to write instruction words into the accelerator's instruction memory and data words into its data memory, then starts execution and waits for halt.
- Reads result words back out of data memory and returns them as a byte-serial valid/ready output stream.

---
 rtl/accel_host_loader_if.sv | 15 +
 rtl/accel_host_loader.sv | 185 ++++++++++++++++++
 tb/tb_accel_host_loader.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_host_loader_if.sv
// Host-side byte streams of the accelerator loader: command bytes in, response bytes out.
// The loader takes the slave view; the host (or a bench) takes the master view.
interface accel_host_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/accel_host_loader.sv
// Host loader: turns a byte-serial command stream into instruction/data memory writes,
// run/halt sequencing and byte-serial memory read-back for the matrix/vector accelerator.
module accel_host_loader #(
   parameter int NUM_SIZE         = 16,
   parameter int INSTR_WIDTH      = 32,
   parameter int NUM_INSTRUCTIONS = 16,
   parameter int WORDS_IN_MEMORY  = 32,
   parameter int RUN_TIMEOUT      = 1024
) (
   input  logic                                clk,
   input  logic                                rst,
   accel_host_loader_if.slave                  host,
   output logic                                instr_we,
   output logic [$clog2(NUM_INSTRUCTIONS)-1:0] instr_waddr,
   output logic [INSTR_WIDTH-1:0]              instr_wdata,
   output logic                                mem_we,
   output logic [$clog2(WORDS_IN_MEMORY)-1:0]  mem_addr,
   output logic [NUM_SIZE-1:0]                 mem_wdata,
   input  logic [NUM_SIZE-1:0]                 mem_rdata,
   output logic                                acc_start,
   input  logic                                acc_halted,
   output logic                                busy,
   output logic                                error
);
   localparam int IA = $clog2(NUM_INSTRUCTIONS);
   localparam int DA = $clog2(WORDS_IN_MEMORY);
   localparam int AW = (IA > DA) ? IA : DA;
   localparam int IB = INSTR_WIDTH / 8;
   localparam int DB = NUM_SIZE / 8;
   localparam int BW = $clog2(IB + 1);
   localparam int TW = $clog2(RUN_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_HEADER, S_COUNT, S_PAYLOAD, S_WRITE, S_RUN_WAIT, S_RD_LO, S_RD_HI, S_STATUS
   } state_t;

   typedef enum logic [1:0] {
      T_LOAD_INSTR = 2'b00, T_LOAD_DATA = 2'b01, T_RUN = 2'b10, T_READ = 2'b11
   } cmd_t;

   state_t                 state_q, state_d;
   cmd_t                   cmd_q;
   logic [AW-1:0]          addr_q;
   logic [7:0]             count_q;
   logic [BW-1:0]          byte_q;
   logic [INSTR_WIDTH-1:0] word_q;
   logic [TW-1:0]          timer_q;
   logic [7:0]             status_q;
   logic                   error_q;

   logic          in_hs, out_hs, last_byte, timed_out;
   logic [AW-1:0] addr_next, hdr_addr;

   assign in_hs     = host.in_valid && host.in_ready;
   assign out_hs    = host.out_valid && host.out_ready;
   assign last_byte = (cmd_q == T_LOAD_INSTR) ? (byte_q == BW'(IB - 1)) : (byte_q == BW'(DB - 1));
   assign timed_out = !acc_halted && (timer_q == TW'(RUN_TIMEOUT - 1));

   // Instruction and data addresses wrap at their own memory depth.
   always_comb begin
      addr_next = addr_q + AW'(1);
      if (cmd_q == T_LOAD_INSTR) begin
         if (addr_q == AW'(NUM_INSTRUCTIONS - 1)) addr_next = '0;
      end else begin
         if (addr_q == AW'(WORDS_IN_MEMORY - 1)) addr_next = '0;
      end
   end

   assign hdr_addr = (host.in_data[7:6] == T_LOAD_INSTR) ? AW'(host.in_data[IA-1:0])
                                                          : AW'(host.in_data[DA-1:0]);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_HEADER;
      else      state_q <= state_d;
   end

   // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      host.in_ready = 1'b0;
      host.out_valid = 1'b0;
      host.out_data = 8'h00;
      instr_we      = 1'b0;
      mem_we        = 1'b0;
      acc_start     = 1'b0;
      busy          = (state_q != S_HEADER);
      case (state_q)
         S_HEADER: begin
            host.in_ready = 1'b1;
            if (in_hs) state_d = (host.in_data[7:6] == T_RUN) ? S_RUN_WAIT : S_COUNT;
         end
         S_COUNT: begin
            host.in_ready = 1'b1;
            if (in_hs) begin
               if (host.in_data == 8'd0)  state_d = S_HEADER;
               else if (cmd_q == T_READ)  state_d = S_RD_LO;
               else                       state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            host.in_ready = 1'b1;
            if (in_hs && last_byte) state_d = S_WRITE;
         end
         S_WRITE: begin
            instr_we = (cmd_q == T_LOAD_INSTR);
            mem_we   = (cmd_q == T_LOAD_DATA);
            state_d  = (count_q == 8'd1) ? S_HEADER : S_PAYLOAD;
         end
         S_RUN_WAIT: begin
            // The timer is zero only on the first cycle here, which carries the start pulse.
            acc_start = (timer_q == '0);
            if (acc_halted || timed_out) state_d = S_STATUS;
         end
         S_RD_LO: begin
            host.out_valid = 1'b1;
            host.out_data  = mem_rdata[7:0];
            if (out_hs) state_d = S_RD_HI;
         end
         S_RD_HI: begin
            host.out_valid = 1'b1;
            host.out_data  = mem_rdata[15:8];
            if (out_hs) state_d = (count_q == 8'd1) ? S_HEADER : S_RD_LO;
         end
         S_STATUS: begin
            host.out_valid = 1'b1;
            host.out_data  = status_q;
            if (out_hs) state_d = S_HEADER;
         end
         default: state_d = S_HEADER;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q    <= T_LOAD_INSTR;
         addr_q   <= '0;
         count_q  <= '0;
         byte_q   <= '0;
         word_q   <= '0;
         timer_q  <= '0;
         status_q <= '0;
         error_q  <= 1'b0;
      end else begin
         if (state_q != S_RUN_WAIT) timer_q <= '0;
         case (state_q)
            S_HEADER: if (in_hs) begin
               cmd_q  <= cmd_t'(host.in_data[7:6]);
               addr_q <= hdr_addr;
               byte_q <= '0;
            end
            S_COUNT: if (in_hs) count_q <= host.in_data;
            S_PAYLOAD: if (in_hs) begin
               for (int k = 0; k < IB; k++)
                  if (byte_q == BW'(k)) word_q[k*8 +: 8] <= host.in_data;
               byte_q <= last_byte ? '0 : byte_q + BW'(1);
            end
            S_WRITE: begin
               addr_q  <= addr_next;
               count_q <= count_q - 8'd1;
            end
            S_RUN_WAIT: begin
               timer_q <= timer_q + TW'(1);
               if (acc_halted) begin
                  status_q <= 8'hA5;
               end else if (timed_out) begin
                  status_q <= 8'hEE;
                  error_q  <= 1'b1;
               end
            end
            S_RD_HI: if (out_hs) begin
               addr_q  <= addr_next;
               count_q <= count_q - 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign instr_waddr = addr_q[IA-1:0];
   assign instr_wdata = word_q;
   assign mem_addr    = addr_q[DA-1:0];
   assign mem_wdata   = word_q[NUM_SIZE-1:0];
   assign error       = error_q;
endmodule

// File: tb/tb_accel_host_loader.sv
// Randomized bench for accel_host_loader: memory-level reference model, write-strobe timing,
// run/status latency and output-stream stall behaviour.
module tb_accel_host_loader;
   localparam int RUN_TIMEOUT = 16;
   localparam int NI = 16;
   localparam int NW = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_we, mem_we, acc_start, acc_halted, busy, error;
   logic [3:0]  instr_waddr;
   logic [31:0] instr_wdata;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   accel_host_loader_if host ();

   accel_host_loader #(
      .NUM_SIZE(16), .INSTR_WIDTH(32), .NUM_INSTRUCTIONS(NI),
      .WORDS_IN_MEMORY(NW), .RUN_TIMEOUT(RUN_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .host(host),
      .instr_we(instr_we), .instr_waddr(instr_waddr), .instr_wdata(instr_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .acc_start(acc_start), .acc_halted(acc_halted), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   // Accelerator memories written by the DUT strobes, and the model's view of what they should hold.
   logic [15:0] dmem [NW];
   logic [31:0] imem [NI];
   logic [15:0] exp_dmem [NW];
   logic [31:0] exp_imem [NI];
   bit          exp_err;
   assign mem_rdata = dmem[mem_addr];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int start_cnt = 0;
   int gap_max = 0;
   bit rdy_tog = 1'b0;

   typedef struct {
      int          cyc;
      bit          is_i;
      int          addr;
      logic [31:0] data;
      logic        rdy;
   } wr_t;
   wr_t wq[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait budget expired, got no event, expected one", tag);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (instr_we || mem_we) check("we exclusive", instr_we && mem_we, 1'b0);
      if (instr_we) begin
         wq.push_back('{cyc, 1'b1, int'(instr_waddr), instr_wdata, host.in_ready});
         imem[instr_waddr] = instr_wdata;
      end
      if (mem_we) begin
         wq.push_back('{cyc, 1'b0, int'(mem_addr), {16'h0, mem_wdata}, host.in_ready});
         dmem[mem_addr] = mem_wdata;
      end
      if (acc_start) start_cnt++;
   end

   // Called at posedge+1; returns at posedge+1 after the byte was taken.
   task automatic send_byte(input logic [7:0] b, output int acc_cyc);
      int   n = 0;
      logic rdy;
      for (int g = $urandom_range(gap_max); g > 0; g--) begin
         @(posedge clk); #1;
      end
      host.in_valid = 1'b1;
      host.in_data  = b;
      do begin
         @(negedge clk);
         rdy     = host.in_ready;
         acc_cyc = cyc;
         @(posedge clk); #1;
         n++;
      end while (!rdy && n < 50);
      if (!rdy) bound_fail("in_ready");
      host.in_valid = 1'b0;
      host.in_data  = 8'($urandom);
   endtask

   // mode 0: always ready, 1: ready toggling every cycle, 2: random ready.
   task automatic recv_byte(input int mode, output logic [7:0] b);
      int         n = 0;
      bit         seen = 1'b0;
      logic [7:0] held = 8'h00;
      forever begin
         rdy_tog = ~rdy_tog;
         case (mode)
            0:       host.out_ready = 1'b1;
            1:       host.out_ready = rdy_tog;
            default: host.out_ready = ($urandom_range(1) == 1);
         endcase
         @(negedge clk);
         if (seen) begin
            check("out_valid hold", host.out_valid, 1'b1);
            check("out_data hold", host.out_data, held);
         end
         if (host.out_valid) begin
            seen = 1'b1;
            held = host.out_data;
            if (host.out_ready) begin
               b = host.out_data;
               @(posedge clk); #1;
               host.out_ready = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
         n++;
         if (n >= 2000) begin
            bound_fail("out_valid");
            b = 8'h00;
            return;
         end
      end
   endtask

   task automatic load(input bit is_i, input logic [4:0] a, input logic [31:0] w[$]);
      int          n = w.size();
      int          nb = is_i ? 4 : 2;
      int          depth = is_i ? NI : NW;
      int          a0 = is_i ? int'(a[3:0]) : int'(a);
      int          s0 = start_cnt;
      int          acc, ad;
      logic [31:0] cur;
      wr_t         exp_q[$];
      wq.delete();
      send_byte({is_i ? 2'b00 : 2'b01, 1'b0, a}, acc);
      send_byte(8'(n), acc);
      for (int i = 0; i < n; i++) begin
         cur = is_i ? w[i] : {16'h0, w[i][15:0]};
         for (int k = 0; k < nb; k++) send_byte(cur[8*k +: 8], acc);
         ad = (a0 + i) % depth;
         exp_q.push_back('{acc + 1, is_i, ad, cur, 1'b0});
         if (is_i) exp_imem[ad] = cur;
         else      exp_dmem[ad] = cur[15:0];
      end
      @(negedge clk);
      @(negedge clk);
      check("load idle busy", busy, 1'b0);
      @(posedge clk); #1;
      check("load write count", wq.size(), exp_q.size());
      for (int i = 0; i < n && i < wq.size(); i++) begin
         check($sformatf("wr%0d cycle", i), wq[i].cyc, exp_q[i].cyc);
         check($sformatf("wr%0d kind", i), wq[i].is_i, exp_q[i].is_i);
         check($sformatf("wr%0d addr", i), wq[i].addr, exp_q[i].addr);
         check($sformatf("wr%0d data", i), wq[i].data, exp_q[i].data);
         check($sformatf("wr%0d in_ready", i), wq[i].rdy, 1'b0);
      end
      check("load no start", start_cnt, s0);
   endtask

   task automatic do_read(input logic [4:0] a, input int n, input int mode);
      int          acc;
      int          s0 = start_cnt;
      logic [7:0]  b;
      logic [15:0] e;
      wq.delete();
      send_byte({2'b11, 1'b0, a}, acc);
      send_byte(8'(n), acc);
      for (int i = 0; i < n; i++) begin
         e = exp_dmem[(int'(a) + i) % NW];
         recv_byte(mode, b);
         check($sformatf("rd%0d lo", i), b, e[7:0]);
         recv_byte(mode, b);
         check($sformatf("rd%0d hi", i), b, e[15:8]);
      end
      @(negedge clk);
      check("read idle busy", busy, 1'b0);
      @(posedge clk); #1;
      check("read no writes", wq.size(), 0);
      check("read no start", start_cnt, s0);
   endtask

   // d: cycle of RUN_WAIT (0 = start cycle) in which acc_halted is seen high; <0 means never.
   task automatic do_run(input logic [7:0] hdr, input int d);
      int         acc, n, s, lat, exp_lat;
      int         s0 = start_cnt;
      bit         hit = (d >= 0 && d < RUN_TIMEOUT);
      logic [7:0] b;
      acc_halted = (d == 0);
      send_byte(hdr, acc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!acc_start && n < 20);
      if (!acc_start) bound_fail("acc_start");
      s = cyc;
      check("start timing", s, acc + 1);
      lat = 0;
      while (!host.out_valid && lat < RUN_TIMEOUT + 10) begin
         if (d > 0 && lat == d) acc_halted = 1'b1;
         @(negedge clk);
         lat++;
      end
      exp_lat = hit ? d + 1 : RUN_TIMEOUT;
      check("run latency", lat, exp_lat);
      check("run busy", busy, 1'b1);
      @(posedge clk); #1;
      recv_byte(2, b);
      check("status byte", b, hit ? 8'hA5 : 8'hEE);
      if (!hit) exp_err = 1'b1;
      acc_halted = 1'b0;
      @(negedge clk);
      check("error flag", error, exp_err);
      check("run idle busy", busy, 1'b0);
      check("single start", start_cnt - s0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ws[$];
      int          acc;
      rst            = 1'b0;
      host.in_valid  = 1'b0;
      host.in_data   = 8'h00;
      host.out_ready = 1'b0;
      acc_halted     = 1'b0;
      exp_err        = 1'b0;
      for (int i = 0; i < NW; i++) begin
         dmem[i]     = 16'($urandom);
         exp_dmem[i] = dmem[i];
      end
      for (int i = 0; i < NI; i++) begin
         imem[i]     = '0;
         exp_imem[i] = '0;
      end
      #3;
      check("reset in_ready", host.in_ready, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset out_valid", host.out_valid, 1'b0);
      check("reset error", error, 1'b0);
      check("reset acc_start", acc_start, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;

      // Directed scenarios.
      ws = {32'h0005, 32'hFFFE};
      load(1'b0, 5'd2, ws);
      ws = {32'h0004_0000, 32'h0028_0000};
      load(1'b1, 5'd15, ws);
      do_run(8'h80, 5);
      do_run(8'h80, -1);
      do_run(8'h80, 0);
      ws = {32'h1234, 32'hABCD};
      load(1'b0, 5'd31, ws);
      do_read(5'd31, 2, 1);
      ws = {};
      load(1'b0, 5'd7, ws);
      do_read(5'd7, 0, 0);

      // Reset in the middle of an instruction word.
      wq.delete();
      send_byte(8'h03, acc);
      send_byte(8'h01, acc);
      send_byte(8'h11, acc);
      send_byte(8'h22, acc);
      send_byte(8'h33, acc);
      #2 rst = 1'b0;
      #1;
      check("midreset in_ready", host.in_ready, 1'b1);
      check("midreset busy", busy, 1'b0);
      check("midreset instr_we", instr_we, 1'b0);
      check("midreset wdata", instr_wdata, 32'h0);
      check("midreset error", error, 1'b0);
      exp_err = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      check("midreset no write", wq.size(), 0);
      ws = {32'hCAFE_F00D};
      load(1'b1, 5'd3, ws);

      // Randomized traffic with idle gaps and stalls.
      gap_max = 2;
      for (int it = 0; it < 30; it++) begin
         int op = $urandom_range(3);
         int n  = $urandom_range(5);
         ws = {};
         for (int i = 0; i < n; i++) ws.push_back($urandom);
         case (op)
            0: load(1'b0, 5'($urandom), ws);
            1: load(1'b1, 5'($urandom), ws);
            2: do_read(5'($urandom), n, 2);
            default: do_run({2'b10, 6'($urandom)}, $urandom_range(RUN_TIMEOUT + 4));
         endcase
      end

      for (int i = 0; i < NI; i++) check($sformatf("imem[%0d]", i), imem[i], exp_imem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
